// File: rtl/floo_serial_link_flit_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : floo_serial_link_flit_scheduler
// Description : Weighted round-robin scheduler that shares one serial-link
//               transmit path between the narrow_req (0), narrow_rsp (1) and
//               wide (2) flit channels. The granted flit is captured in a
//               registered output stage together with its source channel.
// Ports       : clk_i/rst_i   clock, synchronous active-high reset
//               en_i          enable new grants
//               weight_i      per-channel weights, [0]=narrow_req .. [2]=wide
//               valid_i/ready_o/data_i   per-channel flit inputs
//               valid_o/ready_i/data_o/chan_o   buffered output flit
//               busy_o        output buffered or any input pending
// Revision    : 1.0 - initial release
// ============================================================================
module floo_serial_link_flit_scheduler #(
   parameter int unsigned DataWidth   = 512,
   parameter int unsigned WeightWidth = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       en_i,
   input  logic [3*WeightWidth-1:0]   weight_i,
   input  logic [2:0]                 valid_i,
   output logic [2:0]                 ready_o,
   input  logic [3*DataWidth-1:0]     data_i,
   output logic                       valid_o,
   input  logic                       ready_i,
   output logic [DataWidth-1:0]       data_o,
   output logic [1:0]                 chan_o,
   output logic                       busy_o
);

   localparam logic [WeightWidth-1:0] CntOne = WeightWidth'(1);
   localparam logic [WeightWidth-1:0] CntMax = {WeightWidth{1'b1}};

   logic [1:0]             ptr_q, ptr_d;
   logic [WeightWidth-1:0] cnt_q, cnt_d;
   logic                   valid_q, valid_d;
   logic [DataWidth-1:0]   data_q, data_d;
   logic [1:0]             chan_q, chan_d;

   logic [WeightWidth-1:0] eff_w [3];
   logic [1:0]             nxt1, nxt2;
   logic                   slot_free;
   logic                   gnt_vld;
   logic [1:0]             gnt_ch;

   // A zero weight still gives the channel one flit per turn.
   always_comb begin
      for (int c = 0; c < 3; c++) begin
         eff_w[c] = weight_i[c*WeightWidth +: WeightWidth];
         if (eff_w[c] == '0) eff_w[c] = CntOne;
      end
   end

   // Search order after the current turn ends: ptr+1, ptr+2, ptr (mod 3).
   always_comb begin
      nxt1 = (ptr_q == 2'd2) ? 2'd0 : ptr_q + 2'd1;
      nxt2 = (nxt1  == 2'd2) ? 2'd0 : nxt1  + 2'd1;
   end

   assign slot_free = !valid_q | ready_i;

   always_comb begin
      gnt_vld = 1'b0;
      gnt_ch  = ptr_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      if (en_i && slot_free && !rst_i) begin
         if (valid_i[ptr_q] && (cnt_q < eff_w[ptr_q])) begin
            // Continue the current turn.
            gnt_vld = 1'b1;
            gnt_ch  = ptr_q;
            cnt_d   = (cnt_q == CntMax) ? cnt_q : cnt_q + CntOne;
         end else if (valid_i[nxt1]) begin
            gnt_vld = 1'b1;
            gnt_ch  = nxt1;
            ptr_d   = nxt1;
            cnt_d   = CntOne;
         end else if (valid_i[nxt2]) begin
            gnt_vld = 1'b1;
            gnt_ch  = nxt2;
            ptr_d   = nxt2;
            cnt_d   = CntOne;
         end else if (valid_i[ptr_q]) begin
            // Only the current channel is valid: it starts a fresh turn.
            gnt_vld = 1'b1;
            gnt_ch  = ptr_q;
            cnt_d   = CntOne;
         end else begin
            cnt_d   = '0;
         end
      end
   end

   assign ready_o = gnt_vld ? (3'b001 << gnt_ch) : 3'b000;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      chan_d  = chan_q;
      if (gnt_vld) begin
         valid_d = 1'b1;
         chan_d  = gnt_ch;
         case (gnt_ch)
            2'd0:    data_d = data_i[0*DataWidth +: DataWidth];
            2'd1:    data_d = data_i[1*DataWidth +: DataWidth];
            default: data_d = data_i[2*DataWidth +: DataWidth];
         endcase
      end else if (ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q   <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
         chan_q  <= '0;
      end else begin
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         chan_q  <= chan_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign chan_o  = chan_q;
   assign busy_o  = valid_q | (|valid_i);

endmodule
`default_nettype wire

// File: tb/tb_floo_serial_link_flit_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_floo_serial_link_flit_scheduler
// Description : Directed self-checking bench for the WRR flit scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_floo_serial_link_flit_scheduler;

   localparam int unsigned DW = 32;
   localparam int unsigned WW = 4;

   logic            clk = 1'b0;
   logic            rst_i;
   logic            en_i;
   logic [3*WW-1:0] weight_i;
   logic [2:0]      valid_i;
   logic [2:0]      ready_o;
   logic [3*DW-1:0] data_i;
   logic            valid_o;
   logic            ready_i;
   logic [DW-1:0]   data_o;
   logic [1:0]      chan_o;
   logic            busy_o;

   int n_cmp  = 0;
   int n_fail = 0;
   int seq    = 0;
   logic [DW-1:0] held;

   floo_serial_link_flit_scheduler #(.DataWidth(DW), .WeightWidth(WW)) dut (
      .clk_i    (clk),
      .rst_i    (rst_i),
      .en_i     (en_i),
      .weight_i (weight_i),
      .valid_i  (valid_i),
      .ready_o  (ready_o),
      .data_i   (data_i),
      .valid_o  (valid_o),
      .ready_i  (ready_i),
      .data_o   (data_o),
      .chan_o   (chan_o),
      .busy_o   (busy_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Payload encodes the channel in the top byte and a sequence number below.
   function automatic logic [DW-1:0] payload(input int c, input int s);
      return {8'(c), 24'(s)};
   endfunction

   task automatic drive_data();
      data_i = {payload(2, seq), payload(1, seq), payload(0, seq)};
   endtask

   task automatic set_w(input int w0, input int w1, input int w2);
      weight_i = {4'(w2), 4'(w1), 4'(w0)};
   endtask

   // One grant cycle: expect channel g to be granted now and appear next edge.
   task automatic grant_step(input string tag, input int g);
      logic [2:0] e;
      seq++;
      drive_data();
      #1;
      e = 3'b001 << g;
      chk({tag, " ready_o"}, {29'b0, ready_o}, {29'b0, e});
      @(posedge clk); #1;
      chk({tag, " valid_o"}, {31'b0, valid_o}, 32'd1);
      chk({tag, " chan_o"},  {30'b0, chan_o},  32'(g));
      chk({tag, " data_o"},  data_o,           payload(g, seq));
   endtask

   initial begin
      // T1: reset with all channels valid
      rst_i = 1'b1; en_i = 1'b1; ready_i = 1'b1; valid_i = 3'b111;
      set_w(1, 2, 3);
      drive_data();
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         chk("rst ready_o", {29'b0, ready_o}, 32'd0);
         chk("rst valid_o", {31'b0, valid_o}, 32'd0);
         chk("rst chan_o",  {30'b0, chan_o},  32'd0);
         chk("rst data_o",  data_o,           32'd0);
      end
      rst_i = 1'b0;

      // T2: WRR weights {1,2,3}
      grant_step("wrr", 0);
      grant_step("wrr", 1);
      grant_step("wrr", 1);
      grant_step("wrr", 2);
      grant_step("wrr", 2);
      grant_step("wrr", 2);
      grant_step("wrr", 0);
      grant_step("wrr", 1);
      grant_step("wrr", 1);
      grant_step("wrr", 2);

      // T3: zero weight and idle skip
      set_w(0, 4, 4);
      valid_i = 3'b001;
      grant_step("zw", 0);
      grant_step("zw", 0);
      grant_step("zw", 0);
      valid_i = 3'b101;
      grant_step("skip", 2);
      grant_step("skip", 2);
      grant_step("skip", 2);
      grant_step("skip", 2);
      grant_step("skip", 0);
      grant_step("skip", 2);

      // T4: backpressure with a wide flit buffered
      set_w(1, 2, 3);
      valid_i = 3'b111;
      grant_step("bp", 2);
      held = payload(2, seq);
      ready_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         seq++;
         drive_data();
         #1;
         chk("bp ready_o", {29'b0, ready_o}, 32'd0);
         @(posedge clk); #1;
         chk("bp valid_o", {31'b0, valid_o}, 32'd1);
         chk("bp chan_o",  {30'b0, chan_o},  32'd2);
         chk("bp data_o",  data_o,           held);
      end
      ready_i = 1'b1;
      grant_step("bp resume", 2);
      grant_step("bp resume", 0);
      grant_step("bp resume", 1);
      grant_step("bp resume", 1);

      // T5: wide weight lowered mid-turn
      set_w(1, 1, 8);
      grant_step("wchg", 2);
      grant_step("wchg", 2);
      grant_step("wchg", 2);
      set_w(1, 1, 2);
      grant_step("wchg", 0);
      grant_step("wchg", 1);
      grant_step("wchg", 2);
      grant_step("wchg", 2);
      grant_step("wchg", 0);

      // T6: disable with a flit buffered, then reset mid-stream
      en_i = 1'b0;
      #1;
      chk("en0 ready_o", {29'b0, ready_o}, 32'd0);
      @(posedge clk); #1;
      chk("en0 valid_o", {31'b0, valid_o}, 32'd0);
      chk("en0 busy_o",  {31'b0, busy_o},  32'd1);
      chk("en0 ready_o2", {29'b0, ready_o}, 32'd0);
      en_i = 1'b1;
      grant_step("en1", 1);
      rst_i = 1'b1;
      #1;
      chk("mrst ready_o", {29'b0, ready_o}, 32'd0);
      @(posedge clk); #1;
      chk("mrst valid_o", {31'b0, valid_o}, 32'd0);
      chk("mrst chan_o",  {30'b0, chan_o},  32'd0);
      chk("mrst data_o",  data_o,           32'd0);
      rst_i = 1'b0;
      valid_i = 3'b000;
      #1;
      chk("idle ready_o", {29'b0, ready_o}, 32'd0);
      chk("idle busy_o",  {31'b0, busy_o},  32'd0);
      valid_i = 3'b111;
      grant_step("post rst", 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
